// File: rtl/hazard_ctrl.sv
// Hazard/freeze controller: resolves taken-branch flush, load-use stall and
// multi-cycle NACC freeze, and keeps saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memtoreg,
  input  logic             ex_regwrite,
  input  logic             ex_branch_taken,
  input  logic             ex_nacc_start,
  input  logic [1:0]       ex_vl,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             nacc_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             br, ns, lu;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  assign br = ex_branch_taken;
  assign ns = (state_q == RUN) & ex_nacc_start & (ex_vl != 2'd0);
  assign lu = ex_memtoreg & ex_regwrite & (ex_rd != 5'd0) &
              ((id_use_rs1 & (ex_rd == id_rs1)) | (id_use_rs2 & (ex_rd == id_rs2)));

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    nacc_busy  = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (!reset) begin
      if (state_q == BUSY) begin
        // Freeze already committed: every hazard input is ignored here.
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        nacc_busy  = 1'b1;
        if (cnt_q <= 2'd1) begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end else if (br) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (ns) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        nacc_busy  = 1'b1;
        // The start cycle is the first frozen cycle; BUSY covers the rest.
        if (ex_vl != 2'd1) begin
          state_d = BUSY;
          cnt_d   = ex_vl - 2'd1;
        end
      end else if (lu) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  assign stall_d = sat_inc(stall_q, ~pc_write);
  assign flush_d = sat_inc(flush_q, ifid_flush);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (CNT_W=3 and CNT_W=32) on shared inputs,
// checked every cycle against a remaining-freeze-cycles model plus literal checks.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_memtoreg, ex_regwrite;
  logic        ex_branch_taken, ex_nacc_start;
  logic [1:0]  ex_vl;

  logic        pc3, ifw3, iff3, idf3, busy3;
  logic [2:0]  stall3, flush3;
  logic        pc32, ifw32, iff32, idf32, busy32;
  logic [31:0] stall32, flush32;

  int n_tests = 0;
  int n_fail  = 0;

  int     m_freeze = 0;
  longint m_stall  = 0;
  longint m_flush  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_branch_taken(ex_branch_taken), .ex_nacc_start(ex_nacc_start), .ex_vl(ex_vl),
    .pc_write(pc3), .ifid_write(ifw3), .ifid_flush(iff3), .idex_flush(idf3),
    .nacc_busy(busy3), .stall_count(stall3), .flush_count(flush3)
  );

  hazard_ctrl #(.CNT_W(32)) dut32 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_branch_taken(ex_branch_taken), .ex_nacc_start(ex_nacc_start), .ex_vl(ex_vl),
    .pc_write(pc32), .ifid_write(ifw32), .ifid_flush(iff32), .idex_flush(idf32),
    .nacc_busy(busy32), .stall_count(stall32), .flush_count(flush32)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: hazard rules applied directly, freeze tracked as cycles still owed.
  always @(negedge clk) begin
    logic [4:0] e;   // {pc_write, ifid_write, ifid_flush, idex_flush, nacc_busy}
    logic lu_m;
    lu_m = ex_memtoreg && ex_regwrite && ex_rd != 0 &&
           ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    if (reset)                               e = 5'b11000;
    else if (m_freeze > 0)                   e = 5'b00011;
    else if (ex_branch_taken)                e = 5'b11110;
    else if (ex_nacc_start && ex_vl != 0)    e = 5'b00011;
    else if (lu_m)                           e = 5'b00010;
    else                                     e = 5'b11000;
    if (reset) begin
      m_stall = 0;
      m_flush = 0;
    end
    chk("ctl_w3",  {pc3, ifw3, iff3, idf3, busy3}, e);
    chk("ctl_w32", {pc32, ifw32, iff32, idf32, busy32}, e);
    chk("stall_w3",  stall3,  (m_stall > 7) ? 7 : m_stall);
    chk("flush_w3",  flush3,  (m_flush > 7) ? 7 : m_flush);
    chk("stall_w32", stall32, m_stall);
    chk("flush_w32", flush32, m_flush);
    if (reset) begin
      m_freeze = 0;
    end else begin
      if (m_freeze > 0) m_freeze--;
      else if (!ex_branch_taken && ex_nacc_start && ex_vl != 0) m_freeze = int'(ex_vl) - 1;
      if (!e[4]) m_stall++;
      if (e[2])  m_flush++;
    end
  end

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_memtoreg = 0; ex_regwrite = 0;
    ex_branch_taken = 0; ex_nacc_start = 0; ex_vl = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    idle();
    ex_memtoreg = 1; ex_regwrite = 1; ex_rd = rd; id_rs2 = 5'd5; id_use_rs2 = 1;
  endtask

  initial begin
    idle();
    do_reset();

    for (int i = 0; i < 10; i++) tick();
    look();
    chk("idle_pc_write", pc3, 1);
    chk("idle_stall_cnt", stall32, 0);
    chk("idle_flush_cnt", flush32, 0);
    tick();

    set_lu(5'd5);
    look();
    chk("lu_pc_write", pc3, 0);
    chk("lu_idex_flush", idf3, 1);
    tick();
    idle();
    look();
    chk("lu_next_pc_write", pc3, 1);
    chk("lu_stall_cnt", stall32, 1);
    tick();
    set_lu(5'd0);
    look();
    chk("lu_rd0_pc_write", pc3, 1);
    tick();

    do_reset();
    set_lu(5'd5);
    ex_branch_taken = 1;
    look();
    chk("brlu_ifid_flush", iff3, 1);
    chk("brlu_pc_write", pc3, 1);
    tick();
    idle();
    look();
    chk("brlu_flush_cnt", flush32, 1);
    chk("brlu_stall_cnt", stall32, 0);
    tick();

    do_reset();
    ex_nacc_start = 1; ex_vl = 2'd3;
    look();
    chk("nacc3_busy_c0", busy3, 1);
    tick();
    idle();
    ex_branch_taken = 1;
    look();
    chk("nacc3_busy_c1", busy3, 1);
    chk("nacc3_br_no_flush", iff3, 0);
    tick();
    idle();
    look();
    chk("nacc3_busy_c2", busy3, 1);
    tick();
    look();
    chk("nacc3_busy_c3", busy3, 0);
    chk("nacc3_stall_cnt", stall32, 3);
    tick();

    ex_nacc_start = 1; ex_vl = 2'd1;
    look();
    chk("nacc1_busy_c0", busy3, 1);
    tick();
    idle();
    look();
    chk("nacc1_busy_c1", busy3, 0);
    tick();
    ex_nacc_start = 1; ex_vl = 2'd0;
    look();
    chk("nacc0_pc_write", pc3, 1);
    tick();

    do_reset();
    set_lu(5'd5);
    for (int i = 0; i < 10; i++) tick();
    idle();
    look();
    chk("sat_stall_w3", stall3, 7);
    chk("sat_stall_w32", stall32, 10);
    tick();

    ex_nacc_start = 1; ex_vl = 2'd3;
    tick();
    idle();
    tick();
    reset = 1'b1;
    #1;
    chk("rstbusy_pc_write", pc3, 1);
    chk("rstbusy_nacc_busy", busy3, 0);
    chk("rstbusy_stall_cnt", stall32, 0);
    tick();
    reset = 1'b0;
    look();
    chk("rstbusy_no_residual", busy3, 0);
    tick();

    for (int i = 0; i < 600; i++) begin
      reset           = ($urandom_range(0, 99) == 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
      ex_rd           = 5'($urandom_range(0, 3));
      ex_memtoreg     = 1'($urandom_range(0, 1));
      ex_regwrite     = ($urandom_range(0, 3) != 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      ex_nacc_start   = ($urandom_range(0, 5) == 0);
      ex_vl           = 2'($urandom_range(0, 3));
      tick();
    end
    reset = 1'b0;
    idle();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
